// File: rtl/vga_pkg.sv
// Shared VGA timing types: per-axis line timing record and the total-length helper
// used by both axis counters.
package vga_pkg;

  localparam int POS_W     = 12;
  localparam int TOTAL_MAX = 1 << POS_W;

  typedef logic [POS_W-1:0] field_t;
  typedef logic [POS_W:0]   total_t;

  typedef struct packed {
    field_t sync_pulse;
    field_t back_porch;
    field_t visible_area;
    field_t front_porch;
  } line_t;

  // Sum of all four phases, clamped to [1, 2**POS_W] so a counter always has a legal period.
  function automatic total_t line_total(input line_t l);
    logic [POS_W+1:0] sum;
    sum = {2'b00, l.sync_pulse} + {2'b00, l.back_porch}
        + {2'b00, l.visible_area} + {2'b00, l.front_porch};
    if (sum == '0) return total_t'(1);
    if (sum > (POS_W+2)'(TOTAL_MAX)) return total_t'(TOTAL_MAX);
    return sum[POS_W:0];
  endfunction

endpackage

// File: rtl/vga_timing_counter_if.sv
// Timing-configuration channel: requested line timings plus load/pending/ack handshake.
interface vga_timing_counter_if;
  import vga_pkg::*;

  line_t h_line_in;
  line_t v_line_in;
  logic  cfg_load;
  logic  cfg_pending;
  logic  cfg_ack;

  modport master (
    output h_line_in, v_line_in, cfg_load,
    input  cfg_pending, cfg_ack
  );

  modport slave (
    input  h_line_in, v_line_in, cfg_load,
    output cfg_pending, cfg_ack
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One position counter (pixel-in-line or line-in-frame) that wraps against a registered total.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int WIDTH = POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en_i,
  input  logic [WIDTH:0]   total_i,
  output logic [WIDTH-1:0] pos_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] pos_q, pos_d;
  logic             at_end;

  // pos >= total-1: also catches a position left beyond a freshly shrunk total.
  assign at_end = ({1'b0, pos_q} + (WIDTH+1)'(1)) >= total_i;

  always_comb begin
    // NOTE: default first so every path assigns pos_d and no latch is inferred.
    pos_d = pos_q;
    if (step_en_i) pos_d = at_end ? '0 : pos_q + WIDTH'(1);
  end

  // NOTE: non-blocking assignments for state so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) pos_q <= '0;
    else     pos_q <= pos_d;
  end

  assign pos_o  = pos_q;
  assign wrap_o = step_en_i & at_end;

endmodule

// File: rtl/vga_timing_counter.sv
// H/V position generator with shadowed timing that is committed only at a frame boundary,
// so a mode change never produces a torn frame.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int WIDTH = POS_W  // must equal vga_pkg::POS_W (line_t field width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_i,
  vga_timing_counter_if.slave  cfg_if,
  output line_t                h_line_o,
  output line_t                v_line_o,
  output logic [WIDTH-1:0]     h_pos_o,
  output logic [WIDTH-1:0]     v_pos_o,
  output logic                 line_end_o,
  output logic                 frame_end_o
);

  line_t  h_line_q, h_line_d, v_line_q, v_line_d;
  line_t  h_shadow_q, h_shadow_d, v_shadow_q, v_shadow_d;
  logic   pending_q, pending_d;
  logic   ack_q, ack_d;
  total_t h_total_q, v_total_q;
  logic   line_end, frame_end, commit;

  vga_axis_counter #(.WIDTH(WIDTH)) u_h_cnt (
    .clk       (clk),
    .rst       (rst),
    .step_en_i (ce_i),
    .total_i   ((WIDTH+1)'(h_total_q)),
    .pos_o     (h_pos_o),
    .wrap_o    (line_end)
  );

  vga_axis_counter #(.WIDTH(WIDTH)) u_v_cnt (
    .clk       (clk),
    .rst       (rst),
    .step_en_i (line_end),
    .total_i   ((WIDTH+1)'(v_total_q)),
    .pos_o     (v_pos_o),
    .wrap_o    (frame_end)
  );

  assign commit = frame_end & pending_q;

  // A load in the commit cycle refills the shadow after the old value has been taken.
  always_comb begin
    h_line_d   = h_line_q;
    v_line_d   = v_line_q;
    h_shadow_d = h_shadow_q;
    v_shadow_d = v_shadow_q;
    pending_d  = pending_q;
    ack_d      = commit;
    if (commit) begin
      h_line_d  = h_shadow_q;
      v_line_d  = v_shadow_q;
      pending_d = 1'b0;
    end
    if (cfg_if.cfg_load) begin
      h_shadow_d = cfg_if.h_line_in;
      v_shadow_d = cfg_if.v_line_in;
      pending_d  = 1'b1;
    end
  end

  // Totals follow the next-state line so they become valid together with h_line/v_line.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_line_q   <= cfg_if.h_line_in;
      v_line_q   <= cfg_if.v_line_in;
      h_shadow_q <= cfg_if.h_line_in;
      v_shadow_q <= cfg_if.v_line_in;
      h_total_q  <= line_total(cfg_if.h_line_in);
      v_total_q  <= line_total(cfg_if.v_line_in);
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      h_line_q   <= h_line_d;
      v_line_q   <= v_line_d;
      h_shadow_q <= h_shadow_d;
      v_shadow_q <= v_shadow_d;
      h_total_q  <= line_total(h_line_d);
      v_total_q  <= line_total(v_line_d);
      pending_q  <= pending_d;
      ack_q      <= ack_d;
    end
  end

  assign h_line_o           = h_line_q;
  assign v_line_o           = v_line_q;
  assign line_end_o         = line_end;
  assign frame_end_o        = frame_end;
  assign cfg_if.cfg_pending = pending_q;
  assign cfg_if.cfg_ack     = ack_q;

endmodule
